// File: rtl/Cipher_defs.sv
// Cipher_defs: shared AES byte/word types plus sub-word scheduler state and owner encodings.
package Cipher_defs;
  typedef logic [7:0] AESByte;
  typedef AESByte [3:0] AESWord;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} t_sched_state;
  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} t_owner;
endpackage

// File: rtl/sbox.sv
// sbox: combinational AES S-box, multiplicative inverse in GF(2^8) followed by the affine map.
module sbox
  import Cipher_defs::*;
(
  input  AESByte i_byte,
  output AESByte o_byte
);
  function automatic AESByte gf_mul(input AESByte a, input AESByte b);
    AESByte p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  AESByte w_pow, w_inv;
  // x^254 = x^-1 (and 0 maps to 0), built from x^2 * x^4 * ... * x^128
  always_comb begin
    w_pow = gf_mul(i_byte, i_byte);
    w_inv = w_pow;
    for (int k = 0; k < 6; k++) begin
      w_pow = gf_mul(w_pow, w_pow);
      w_inv = gf_mul(w_inv, w_pow);
    end
  end
  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/sub_word_sched.sv
// sub_word_sched: two requesters share one sbox; the granted word is substituted one byte per cycle.
module sub_word_sched
  import Cipher_defs::*;
#(
  parameter bit RR_EN = 1'b1
)
(
  input  logic   clk,
  input  logic   rst,
  input  logic   a_valid,
  input  AESWord a_word,
  output logic   a_ready,
  input  logic   b_valid,
  input  AESWord b_word,
  output logic   b_ready,
  output logic   out_valid,
  output AESWord out_word,
  output logic   out_owner,
  input  logic   out_ready
);
  t_sched_state r_state, w_state_nxt;
  logic [1:0] r_idx;
  AESWord r_word, r_res;
  t_owner r_owner, r_last;
  AESByte w_sbox_out;
  logic w_idle, w_gnt_b, w_accept;
  // B wins only when alone, or on a tie under round-robin after A was served last
  assign w_idle = r_state == ST_IDLE && !rst;
  assign w_gnt_b = b_valid && (!a_valid || (RR_EN && r_last == OWN_A));
  assign a_ready = w_idle && a_valid && !w_gnt_b;
  assign b_ready = w_idle && w_gnt_b;
  assign w_accept = a_ready || b_ready;
  assign out_valid = r_state == ST_DONE;
  assign out_word = r_res;
  assign out_owner = r_owner;
  sbox u_sbox (.i_byte(r_word[r_idx]), .o_byte(w_sbox_out));
  always_comb begin
    w_state_nxt = r_state == ST_IDLE ? (w_accept ? ST_BUSY : ST_IDLE)
                : r_state == ST_BUSY ? (r_idx == 2'd3 ? ST_DONE : ST_BUSY)
                : (out_ready ? ST_IDLE : ST_DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx <= '0;
      r_word <= '0;
      r_res <= '0;
      r_owner <= OWN_A;
      r_last <= OWN_B;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_word <= w_gnt_b ? b_word : a_word;
        r_owner <= w_gnt_b ? OWN_B : OWN_A;
        r_last <= w_gnt_b ? OWN_B : OWN_A;
        r_idx <= '0;
      end
      if (r_state == ST_BUSY) begin
        r_res[r_idx] <= w_sbox_out;
        r_idx <= r_idx + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_sub_word_sched.sv
// tb_sub_word_sched: table vectors, corner sequences and random ops against a GF(2^8) reference model.
module tb_sub_word_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a_word = '0, b_word = '0;
  logic a_ready, b_ready, out_valid, out_owner;
  logic [31:0] out_word;
  logic a_ready0, b_ready0, out_valid0, out_owner0;
  logic [31:0] out_word0;
  int n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  sub_word_sched #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_word(a_word), .a_ready(a_ready),
    .b_valid(b_valid), .b_word(b_word), .b_ready(b_ready), .out_valid(out_valid),
    .out_word(out_word), .out_owner(out_owner), .out_ready(out_ready));
  sub_word_sched #(.RR_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_word(a_word), .a_ready(a_ready0),
    .b_valid(b_valid), .b_word(b_word), .b_ready(b_ready0), .out_valid(out_valid0),
    .out_word(out_word0), .out_owner(out_owner0), .out_ready(out_ready));
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction
  // Inverse by exhaustive search, then the FIPS-197 bitwise affine definition
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 0; c = 8'h63;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
    return s;
  endfunction
  function automatic logic [31:0] ref_sub(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_sbox(w[8*i +: 8]);
    return r;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1; a_valid = 1; b_valid = 1; out_ready = 0;
    @(posedge clk); @(negedge clk); #1;
    chk("rst_a_ready", {31'b0, a_ready}, 0);
    chk("rst_b_ready", {31'b0, b_ready}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_owner", {31'b0, out_owner}, 0);
    rst = 0; a_valid = 0; b_valid = 0;
  endtask
  task automatic run_op(input logic av, input logic bv, input logic [31:0] aw, input logic [31:0] bw,
                        input int stall, output logic gb, output logic own, output logic [31:0] wd,
                        output int lat, output logic rdy_ok, output logic stable_ok, output logic pulse_ok);
    int w;
    a_valid = av; b_valid = bv; a_word = aw; b_word = bw; out_ready = 0; #1;
    w = 0;
    while (!(a_ready && a_valid) && !(b_ready && b_valid) && w < 10) begin
      @(posedge clk); @(negedge clk); #1; w++;
    end
    rdy_ok = (w < 10) && !(a_ready && b_ready);
    gb = b_ready;
    @(posedge clk); @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 20) begin
      a_valid = 1'($urandom); b_valid = 1'($urandom); a_word = $urandom; b_word = $urandom; #1;
      if (a_ready || b_ready) rdy_ok = 0;
      @(posedge clk); @(negedge clk); lat++;
    end
    own = out_owner; wd = out_word; stable_ok = out_valid;
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < stall; i++) begin
      #1; if (a_ready || b_ready) stable_ok = 0;
      @(posedge clk); @(negedge clk);
      if (!out_valid || out_word !== wd || out_owner !== own) stable_ok = 0;
    end
    a_valid = 0; b_valid = 0; out_ready = 1;
    @(posedge clk); @(negedge clk);
    pulse_ok = !out_valid;
    out_ready = 0;
  endtask
  task automatic op_check(input string nm, input logic av, input logic bv, input logic [31:0] aw,
                          input logic [31:0] bw, input int stall, input logic eo, input logic [31:0] ew);
    logic gb, own, rdy_ok, stable_ok, pulse_ok;
    logic [31:0] wd;
    int lat;
    run_op(av, bv, aw, bw, stall, gb, own, wd, lat, rdy_ok, stable_ok, pulse_ok);
    chk({nm, "_grant_b"}, {31'b0, gb}, {31'b0, eo});
    chk({nm, "_owner"}, {31'b0, own}, {31'b0, eo});
    chk({nm, "_word"}, wd, ew);
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_ready_excl"}, {31'b0, rdy_ok}, 1);
    chk({nm, "_done_stable"}, {31'b0, stable_ok}, 1);
    chk({nm, "_valid_drop"}, {31'b0, pulse_ok}, 1);
  endtask
  typedef struct {
    logic av, bv;
    logic [31:0] aw, bw, ew;
    logic eo;
  } vec_t;
  vec_t tbl[9];
  initial begin
    int bseen, pulses, bad, gapbad, lastp, ov;
    logic m_last, av, bv, egb;
    logic [31:0] aw, bw;
    tbl[0] = '{1, 1, 32'h10101010, 32'h00000000, 32'hCACACACA, 0};
    tbl[1] = '{1, 1, 32'h10101010, 32'h00000000, 32'h63636363, 1};
    tbl[2] = '{1, 1, 32'h10101010, 32'h00000000, 32'hCACACACA, 0};
    tbl[3] = '{1, 0, 32'hFF530100, 32'h00000000, 32'h16ED7C63, 0};
    tbl[4] = '{0, 1, 32'h00000000, 32'hFF530100, 32'h16ED7C63, 1};
    tbl[5] = '{1, 1, 32'h01010101, 32'h53535353, 32'h7C7C7C7C, 0};
    tbl[6] = '{0, 1, 32'h00000000, 32'h10101010, 32'hCACACACA, 1};
    tbl[7] = '{1, 1, 32'h00000000, 32'h01010101, 32'h63636363, 0};
    tbl[8] = '{1, 1, 32'h53535353, 32'hFFFFFFFF, 32'h16161616, 1};
    do_reset();
    for (int i = 0; i < 9; i++)
      op_check($sformatf("tbl%0d", i), tbl[i].av, tbl[i].bv, tbl[i].aw, tbl[i].bw, 0, tbl[i].eo, tbl[i].ew);
    // result held while the consumer stalls, then IDLE right after the handshake
    do_reset();
    op_check("stall", 1, 0, 32'hA5C30F01, 32'h0, 5, 0, ref_sub(32'hA5C30F01));
    a_valid = 1; b_valid = 0; #1;
    chk("post_hs_a_ready", {31'b0, a_ready}, 1);
    b_valid = 1; #1;
    chk("post_hs_tie_b_ready", {31'b0, b_ready}, 1);
    chk("post_hs_tie_a_ready", {31'b0, a_ready}, 0);
    a_valid = 0; b_valid = 0;
    // reset at idx=2 of a B operation
    do_reset();
    b_valid = 1; b_word = 32'h12345678; #1;
    chk("b_only_ready", {31'b0, b_ready}, 1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1; a_valid = 1; b_valid = 1;
    @(posedge clk); @(negedge clk); #1;
    chk("midrst_a_ready", {31'b0, a_ready}, 0);
    chk("midrst_b_ready", {31'b0, b_ready}, 0);
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    rst = 0; #1;
    chk("midrst_tie_a_ready", {31'b0, a_ready}, 1);
    a_valid = 0; b_valid = 0;
    ov = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) ov++;
    end
    chk("midrst_no_output", ov, 0);
    op_check("midrst_next", 1, 1, 32'h00FF5310, 32'h77777777, 0, 0, ref_sub(32'h00FF5310));
    // fixed priority instance with both requesters held valid
    do_reset();
    a_valid = 1; b_valid = 1; a_word = 32'h10101010; b_word = 0; out_ready = 1;
    bseen = 0; pulses = 0; bad = 0; gapbad = 0; lastp = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (b_ready0) bseen++;
      if (out_valid0) begin
        pulses++;
        if (out_owner0 !== 1'b0 || out_word0 !== 32'hCACACACA) bad++;
        if (lastp >= 0 && c - lastp != 6) gapbad++;
        lastp = c;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("fixed_b_ready_seen", bseen, 0);
    chk("fixed_pulses", pulses, 6);
    chk("fixed_bad_results", bad, 0);
    chk("fixed_issue_interval", gapbad, 0);
    a_valid = 0; b_valid = 0; out_ready = 0;
    // randomized operations against the reference model
    do_reset();
    m_last = 1;
    for (int i = 0; i < 40; i++) begin
      av = 1'($urandom); bv = 1'($urandom);
      if (!av && !bv) av = 1;
      aw = $urandom; bw = $urandom;
      egb = bv && (!av || m_last == 1'b0);
      op_check($sformatf("rnd%0d", i), av, bv, aw, bw, $urandom_range(0, 3), egb, ref_sub(egb ? bw : aw));
      m_last = egb;
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
